pipe_mux: RTL and testbench

Parametrised C-way, W-bit registered multiplexer with a valid/ready handshake on both sides. It replaces the combinational 2:1 select in datapath paths that need a register stage, such as operand/forwarding select and writeback source select. It also tags each output word with the channel it came from and flags an out-of-range select. An optional skid buffer sustains one transfer per cycle with a fully registered `in_ready`.

---
 rtl/pipe_mux.sv | 138 +++++++++++++
 tb/tb_pipe_mux.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mux.sv
// pipe_mux: C-way, W-bit registered multiplexer with valid/ready on both sides.
//
// Each accepted word is captured together with the channel index that
// produced it. A select at or beyond C (only reachable when C is not a power
// of two) captures zero data, raises out_err with that word, and latches
// err_sticky until reset.
//
// Build option:
//   PIPE_MUX_SKID_EN  defined   -> one-entry skid register behind the output
//                                  register; in_ready comes straight from a
//                                  flop, and full throughput is kept under
//                                  backpressure.
//                     undefined -> output register only; in_ready is
//                                  ~out_valid | out_ready (combinational).
//
// Ports:
//   clk, rst_n                clock, async active-low reset
//   in_data[C*W-1:0]          flattened channels, channel k = in_data[k*W +: W]
//   in_sel[SW-1:0]            binary channel select
//   in_valid / in_ready       upstream handshake
//   out_data[W-1:0]           selected data
//   out_sel[SW-1:0]           channel index of out_data
//   out_err                   out_sel was out of range (out_data forced to 0)
//   out_valid / out_ready     downstream handshake
//   err_sticky                set by any accepted out-of-range select
module pipe_mux #(
  parameter int W = 32,
  parameter int C = 4,
  localparam int SW = $clog2(C)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [C*W-1:0] in_data,
  input  logic [SW-1:0]  in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_err,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           err_sticky
);

  logic [31:0]  sel_ext;
  logic [W-1:0] cap_data;
  logic         cap_err;
  logic         in_xfer;
  logic         or_load;

  assign sel_ext = 32'(in_sel);
  assign cap_err = (sel_ext >= 32'(C));

  // Explicit compare loop rather than a variable part-select, so an
  // out-of-range select yields zero instead of indexing past in_data.
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < C; k++) begin
      if (sel_ext == 32'(k)) cap_data = in_data[k*W +: W];
    end
  end

  assign in_xfer = in_valid & in_ready;
  // Output register may take a new word when empty or draining this cycle.
  assign or_load = ~out_valid | out_ready;

`ifdef PIPE_MUX_SKID_EN
  logic [W-1:0]  sk_data;
  logic [SW-1:0] sk_sel;
  logic          sk_err;
  logic          sk_valid;

  // in_ready only depends on the skid flop, never on out_ready.
  assign in_ready = ~sk_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      sk_data   <= '0;
      sk_sel    <= '0;
      sk_err    <= 1'b0;
      sk_valid  <= 1'b0;
    end else if (or_load) begin
      // Skid entry is older than anything on the input, so it goes first.
      // in_ready is low while the skid is full, so no input arrives then.
      if (sk_valid) begin
        out_data  <= sk_data;
        out_sel   <= sk_sel;
        out_err   <= sk_err;
        out_valid <= 1'b1;
        sk_valid  <= 1'b0;
      end else if (in_xfer) begin
        out_data  <= cap_data;
        out_sel   <= in_sel;
        out_err   <= cap_err;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      sk_data  <= cap_data;
      sk_sel   <= in_sel;
      sk_err   <= cap_err;
      sk_valid <= 1'b1;
    end
  end
`else
  assign in_ready = or_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (or_load) begin
      if (in_xfer) begin
        out_data <= cap_data;
        out_sel  <= in_sel;
        out_err  <= cap_err;
      end
      out_valid <= in_xfer;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (in_xfer && cap_err) begin
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_mux.sv
module tb_pipe_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;

  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid, in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_err, out_valid, out_ready, err_sticky;

  logic [95:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3, in_ready3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic         out_err3, out_valid3, out_ready3, err_sticky3;

  pipe_mux #(.W(32), .C(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .err_sticky(err_sticky)
  );

  pipe_mux #(.W(32), .C(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_sel(out_sel3), .out_err(out_err3),
    .out_valid(out_valid3), .out_ready(out_ready3), .err_sticky(err_sticky3)
  );

  int errors = 0;
  int checks = 0;
  int nacc   = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
    logic        e;
  } word_t;

  // Reference model: words accepted but not yet delivered, oldest first.
  word_t       q[$];
  logic [31:0] ch[4];

  typedef struct {
    bit          d3;
    logic [1:0]  sel;
    logic [31:0] base;
    logic [31:0] ed;
    logic        ee;
    logic        es;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle on the C=4 instance with model checking; returns #1 after the edge.
  task automatic step(input bit v, input logic [1:0] s, input bit ordy);
    word_t w;
    bit    exp_ready, acc, drn;
    in_valid  = v;
    in_sel    = s;
    out_ready = ordy;
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = ch[k];
    #1;
`ifdef PIPE_MUX_SKID_EN
    exp_ready = (q.size() < 2);
`else
    exp_ready = (q.size() == 0) || ordy;
`endif
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_sel", {30'd0, out_sel}, {30'd0, q[0].s});
      chk("out_err", {31'd0, out_err}, {31'd0, q[0].e});
    end
    acc = v && exp_ready;
    drn = (q.size() > 0) && ordy;
    w.d = ch[s];
    w.s = s;
    w.e = 1'b0;
    @(posedge clk);
    if (drn) void'(q.pop_front());
    if (acc) begin
      q.push_back(w);
      nacc++;
    end
    #1;
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] wa, wb, wc;
    int          cyc;

    rst_n = 1'b0;
    in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_data3 = '0; in_sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    for (int k = 0; k < 4; k++) ch[k] = '0;

    vt[0] = '{1'b0, 2'd0, 32'h1000_0000, 32'h1000_0000, 1'b0, 1'b0};
    vt[1] = '{1'b0, 2'd1, 32'h1000_0000, 32'h1000_0001, 1'b0, 1'b0};
    vt[2] = '{1'b0, 2'd2, 32'h1000_0000, 32'h1000_0002, 1'b0, 1'b0};
    vt[3] = '{1'b0, 2'd3, 32'h1000_0000, 32'h1000_0003, 1'b0, 1'b0};
    vt[4] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1};
    vt[5] = '{1'b1, 2'd1, 32'hA5A5_0000, 32'hA5A5_0001, 1'b0, 1'b1};
    vt[6] = '{1'b1, 2'd2, 32'h5A5A_0000, 32'h5A5A_0002, 1'b0, 1'b1};
    vt[7] = '{1'b1, 2'd0, 32'h1234_0000, 32'h1234_0000, 1'b0, 1'b1};

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sel", {30'd0, out_sel}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_in_ready3", {31'd0, in_ready3}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back vectors, out_ready high: each result appears one cycle later.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) ch[k] = vt[i].base | 32'(k);
      for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = ch[k];
      for (int k = 0; k < 3; k++) in_data3[k*32 +: 32] = ch[k];
      in_valid   = !vt[i].d3;
      in_valid3  = vt[i].d3;
      in_sel     = vt[i].sel;
      in_sel3    = vt[i].sel;
      out_ready  = 1'b1;
      out_ready3 = 1'b1;
      @(posedge clk);
      #1;
      if (vt[i].d3) begin
        chk("tbl3_valid", {31'd0, out_valid3}, 32'd1);
        chk("tbl3_data", out_data3, vt[i].ed);
        chk("tbl3_sel", {30'd0, out_sel3}, {30'd0, vt[i].sel});
        chk("tbl3_err", {31'd0, out_err3}, {31'd0, vt[i].ee});
        chk("tbl3_sticky", {31'd0, err_sticky3}, {31'd0, vt[i].es});
      end else begin
        chk("tbl_valid", {31'd0, out_valid}, 32'd1);
        chk("tbl_data", out_data, vt[i].ed);
        chk("tbl_sel", {30'd0, out_sel}, {30'd0, vt[i].sel});
        chk("tbl_err", {31'd0, out_err}, {31'd0, vt[i].ee});
        chk("tbl_sticky", {31'd0, err_sticky}, {31'd0, vt[i].es});
      end
    end
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
    @(posedge clk);
    #1;
    chk("tbl3_drained", {31'd0, out_valid3}, 32'd0);
    chk("tbl3_sticky_hold", {31'd0, err_sticky3}, 32'd1);
    chk("tbl_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: A then B with out_ready low, then release.
    wa = 32'hAAAA_0001;
    wb = 32'hBBBB_0002;
    ch[0] = wa; ch[1] = wb;
    step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd1, 1'b0);
    chk("bp_hold_A", out_data, wa);
`ifdef PIPE_MUX_SKID_EN
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    step(1'b0, 2'd0, 1'b1);
    chk("bp_then_B", out_data, wb);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
`else
    step(1'b0, 2'd0, 1'b1);
    chk("bp_B_refused", {31'd0, out_valid}, 32'd0);
`endif
    step(1'b0, 2'd0, 1'b1);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Output held stable under backpressure while inputs keep changing.
    for (int k = 0; k < 4; k++) ch[k] = $urandom;
    held = ch[2];
    step(1'b1, 2'd2, 1'b0);
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 4; k++) ch[k] = $urandom;
      step(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      chk("hold_data", out_data, held);
      chk("hold_sel", {30'd0, out_sel}, 32'd2);
      chk("hold_err", {31'd0, out_err}, 32'd0);
    end
    for (int n = 0; n < 3; n++) step(1'b0, 2'd0, 1'b1);

    // Asynchronous reset mid-cycle with the pipe full.
    ch[0] = 32'hAAAA_1111; ch[1] = 32'hBBBB_2222;
    step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wc = 32'hCCCC_3333;
    ch[3] = wc;
    step(1'b1, 2'd3, 1'b1);
    chk("arst_C", out_data, wc);
    chk("arst_C_valid", {31'd0, out_valid}, 32'd1);
    step(1'b0, 2'd0, 1'b1);
    chk("arst_no_stale", {31'd0, out_valid}, 32'd0);

    // Random traffic against the queue model.
    nacc = 0;
    cyc  = 0;
    while (nacc < 1000 && cyc < 20000) begin
      for (int k = 0; k < 4; k++) ch[k] = $urandom;
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("rand_words", {31'd0, nacc >= 1000}, 32'd1);
    for (int n = 0; n < 4; n++) step(1'b0, 2'd0, 1'b1);
    chk("rand_drained", 32'(q.size()), 32'd0);
    chk("sticky4_clear", {31'd0, err_sticky}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
